// File: rtl/hdmi_symbol_pkg.sv
// Shared TMDS symbol tables, symbol classes and island-tracker states for the HDMI RX path.
package hdmi_symbol_pkg;

  typedef enum logic [1:0] {
    CTRL  = 2'd0,
    TERC4 = 2'd1,
    OTHER = 2'd2
  } sym_class_e;

  typedef enum logic [1:0] {
    S_OTHER  = 2'd0,
    S_CTRL   = 2'd1,
    S_QUAL   = 2'd2,
    S_ISLAND = 2'd3
  } fsm_state_e;

  // Indexed by the decoded nibble.
  localparam logic [9:0] TERC4_TBL [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  // Indexed by {c1,c0}.
  localparam logic [9:0] CTRL_TBL [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

endpackage

// File: rtl/terc4_decode_ch.sv
// Per-channel TMDS symbol classifier: registers class match, TERC4 nibble and control bits.
module terc4_decode_ch
  import hdmi_symbol_pkg::*;
(
  input  logic       clk_1x_in,
  input  logic       rst_in,
  input  logic [9:0] sym_i,
  output logic       is_terc4_o,
  output logic       is_ctrl_o,
  output logic [3:0] nib_o,
  output logic [1:0] ctrl_o
);

  sym_class_e class_d, class_p1_q;
  logic [3:0] nib_d, nib_p1_q;
  logic [1:0] ctrl_d, ctrl_p1_q;

  // The two tables are disjoint, so at most one loop can match.
  always_comb begin
    class_d = OTHER;
    nib_d   = '0;
    ctrl_d  = '0;
    for (int i = 0; i < 16; i++) begin
      if (sym_i == TERC4_TBL[i]) begin
        class_d = TERC4;
        nib_d   = 4'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (sym_i == CTRL_TBL[i]) begin
        class_d = CTRL;
        ctrl_d  = 2'(i);
      end
    end
  end

  // Stage 1 boundary
  always_ff @(posedge clk_1x_in or posedge rst_in) begin
    if (rst_in) begin
      class_p1_q <= OTHER;
      nib_p1_q   <= '0;
      ctrl_p1_q  <= '0;
    end else begin
      class_p1_q <= class_d;
      nib_p1_q   <= nib_d;
      ctrl_p1_q  <= ctrl_d;
    end
  end

  assign is_terc4_o = (class_p1_q == TERC4);
  assign is_ctrl_o  = (class_p1_q == CTRL);
  assign nib_o      = nib_p1_q;
  assign ctrl_o     = ctrl_p1_q;

endmodule

// File: rtl/hdmi_island_detect.sv
// Multi-channel TMDS classifier with data-island qualification FSM, decoded outputs and statistics.
module hdmi_island_detect
  import hdmi_symbol_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int MIN_RUN = 2,
  parameter int MAX_ERR = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk_1x_in,
  input  logic                  rst_in,
  input  logic [10*NUM_CH-1:0]  deser_data,
  output logic [NUM_CH-1:0]     is_terc4,
  output logic [NUM_CH-1:0]     is_ctrl,
  output logic                  island_active,
  output logic                  nib_valid,
  output logic [4*NUM_CH-1:0]   nib_data,
  output logic                  ctrl_valid,
  output logic [2*NUM_CH-1:0]   ctrl_data,
  output logic [CNT_W-1:0]      island_count,
  output logic [CNT_W-1:0]      err_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [4*NUM_CH-1:0] nib_p1;
  logic [2*NUM_CH-1:0] ctrl_p1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    terc4_decode_ch u_dec (
      .clk_1x_in  (clk_1x_in),
      .rst_in     (rst_in),
      .sym_i      (deser_data[10*c +: 10]),
      .is_terc4_o (is_terc4[c]),
      .is_ctrl_o  (is_ctrl[c]),
      .nib_o      (nib_p1[4*c +: 4]),
      .ctrl_o     (ctrl_p1[2*c +: 2])
    );
  end

  logic all_ctrl, all_terc4, mixed;
  assign all_ctrl  = &is_ctrl;
  assign all_terc4 = &is_terc4;
  assign mixed     = !all_ctrl && !all_terc4;

  fsm_state_e state_q, state_d;
  logic [3:0] run_q, run_d, err_run_q, err_run_d;

  // Stage 2 boundary: FSM state
  always_ff @(posedge clk_1x_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_OTHER;
      run_q     <= '0;
      err_run_q <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      err_run_q <= err_run_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    err_run_d = err_run_q;
    if (all_ctrl) begin
      state_d   = S_CTRL;
      run_d     = '0;
      err_run_d = '0;
    end else begin
      case (state_q)
        S_OTHER, S_CTRL: begin
          if (all_terc4) begin
            run_d   = 4'd1;
            state_d = (MIN_RUN == 1) ? S_ISLAND : S_QUAL;
          end else begin
            state_d = S_OTHER;
          end
        end
        S_QUAL: begin
          if (all_terc4) begin
            run_d = run_q + 4'd1;
            if (run_q + 4'd1 == 4'(MIN_RUN)) state_d = S_ISLAND;
          end else begin
            state_d = S_OTHER;
            run_d   = '0;
          end
        end
        S_ISLAND: begin
          if (all_terc4) begin
            err_run_d = '0;
          end else if (err_run_q + 4'd1 == 4'(MAX_ERR)) begin
            state_d   = S_OTHER;
            err_run_d = '0;
          end else begin
            err_run_d = err_run_q + 4'd1;
          end
        end
        default: state_d = S_OTHER;
      endcase
    end
  end

  logic nib_vld_d, isl_entry, err_hit;

  always_comb begin
    nib_vld_d = all_terc4 && (state_d == S_ISLAND);
    isl_entry = (state_d == S_ISLAND) && (state_q != S_ISLAND);
    err_hit   = (state_q == S_ISLAND) && mixed;
  end

  logic                nib_vld_p2_q, ctrl_vld_p2_q;
  logic [4*NUM_CH-1:0] nib_data_p2_q;
  logic [2*NUM_CH-1:0] ctrl_data_p2_q;
  logic [CNT_W-1:0]    isl_cnt_q, err_cnt_q;

  // Stage 2 boundary: decoded outputs and counters
  always_ff @(posedge clk_1x_in or posedge rst_in) begin
    if (rst_in) begin
      nib_vld_p2_q   <= 1'b0;
      nib_data_p2_q  <= '0;
      ctrl_vld_p2_q  <= 1'b0;
      ctrl_data_p2_q <= '0;
      isl_cnt_q      <= '0;
      err_cnt_q      <= '0;
    end else begin
      nib_vld_p2_q   <= nib_vld_d;
      nib_data_p2_q  <= nib_p1;
      ctrl_vld_p2_q  <= all_ctrl;
      ctrl_data_p2_q <= ctrl_p1;
      if (isl_entry) isl_cnt_q <= sat_inc(isl_cnt_q);
      if (err_hit)   err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign island_active = (state_q == S_ISLAND);
  assign nib_valid     = nib_vld_p2_q;
  assign nib_data      = nib_data_p2_q;
  assign ctrl_valid    = ctrl_vld_p2_q;
  assign ctrl_data     = ctrl_data_p2_q;
  assign island_count  = isl_cnt_q;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_hdmi_island_detect.sv
// Scoreboard bench for hdmi_island_detect: directed symbol vectors with hand-computed responses.
module tb_hdmi_island_detect;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] T0  = 10'b1010011100;
  localparam logic [9:0] T3  = 10'b1011100010;
  localparam logic [9:0] T5  = 10'b0100011110;
  localparam logic [9:0] T9  = 10'b0100111001;
  localparam logic [9:0] TA  = 10'b0110011100;
  localparam logic [9:0] VID = 10'b1111111111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] deser = {VID, VID, VID};
  logic [2:0]  is_terc4, is_ctrl;
  logic        island_active, nib_valid, ctrl_valid;
  logic [11:0] nib_data;
  logic [5:0]  ctrl_data;
  logic [1:0]  island_count, err_count;

  hdmi_island_detect #(.NUM_CH(3), .MIN_RUN(2), .MAX_ERR(2), .CNT_W(2)) dut (
    .clk_1x_in    (clk),
    .rst_in       (rst),
    .deser_data   (deser),
    .is_terc4     (is_terc4),
    .is_ctrl      (is_ctrl),
    .island_active(island_active),
    .nib_valid    (nib_valid),
    .nib_data     (nib_data),
    .ctrl_valid   (ctrl_valid),
    .ctrl_data    (ctrl_data),
    .island_count (island_count),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int         due;
    logic [2:0] t;
    logic [2:0] c;
  } exp1_t;

  typedef struct {
    int          due;
    logic        ia;
    logic        nv;
    logic [11:0] nd;
    logic        cv;
    logic [5:0]  cd;
    logic [1:0]  ic;
    logic [1:0]  ec;
  } exp2_t;

  exp1_t q1[$];
  exp2_t q2[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare whichever expectations fall due at this clock.
  always @(negedge clk) begin
    exp1_t e1;
    exp2_t e2;
    if (!rst) begin
      if (q1.size() > 0 && q1[0].due == edge_n) begin
        e1 = q1.pop_front();
        chk("is_terc4", 32'(is_terc4), 32'(e1.t));
        chk("is_ctrl", 32'(is_ctrl), 32'(e1.c));
      end
      if (q2.size() > 0 && q2[0].due == edge_n) begin
        e2 = q2.pop_front();
        chk("island_active", 32'(island_active), 32'(e2.ia));
        chk("nib_valid", 32'(nib_valid), 32'(e2.nv));
        if (e2.nv) chk("nib_data", 32'(nib_data), 32'(e2.nd));
        chk("ctrl_valid", 32'(ctrl_valid), 32'(e2.cv));
        if (e2.cv) chk("ctrl_data", 32'(ctrl_data), 32'(e2.cd));
        chk("island_count", 32'(island_count), 32'(e2.ic));
        chk("err_count", 32'(err_count), 32'(e2.ec));
      end
    end
  end

  task automatic send(input logic [9:0] s0, input logic [9:0] s1, input logic [9:0] s2,
                      input logic [2:0] t, input logic [2:0] c,
                      input logic ia, input logic nv, input logic [11:0] nd,
                      input logic cv, input logic [5:0] cd,
                      input logic [1:0] ic, input logic [1:0] ec);
    exp1_t e1;
    exp2_t e2;
    @(posedge clk);
    #1;
    deser = {s2, s1, s0};
    e1.due = edge_n + 1; e1.t = t; e1.c = c;
    e2.due = edge_n + 2; e2.ia = ia; e2.nv = nv; e2.nd = nd;
    e2.cv = cv; e2.cd = cd; e2.ic = ic; e2.ec = ec;
    q1.push_back(e1);
    q2.push_back(e2);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_is_terc4"}, 32'(is_terc4), 32'd0);
    chk({tag, "_is_ctrl"}, 32'(is_ctrl), 32'd0);
    chk({tag, "_island_active"}, 32'(island_active), 32'd0);
    chk({tag, "_nib_valid"}, 32'(nib_valid), 32'd0);
    chk({tag, "_nib_data"}, 32'(nib_data), 32'd0);
    chk({tag, "_ctrl_valid"}, 32'(ctrl_valid), 32'd0);
    chk({tag, "_ctrl_data"}, 32'(ctrl_data), 32'd0);
    chk({tag, "_island_count"}, 32'(island_count), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() > 0 || q2.size() > 0) && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (q1.size() > 0 || q2.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations still pending, expected 0", q1.size() + q2.size());
      q1.delete();
      q2.delete();
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    //    s0   s1   s2   terc4   ctrl    ia  nv  nd      cv  cd     ic ec
    send(C00, C00, C00, 3'b000, 3'b111, 0, 0, 12'h000, 1, 6'h00, 0, 0);
    send(C00, C00, C00, 3'b000, 3'b111, 0, 0, 12'h000, 1, 6'h00, 0, 0);
    send(T5,  T5,  T5,  3'b111, 3'b000, 0, 0, 12'h000, 0, 6'h00, 0, 0);
    send(T5,  T5,  T5,  3'b111, 3'b000, 1, 1, 12'h555, 0, 6'h00, 1, 0);
    send(T5,  T5,  T5,  3'b111, 3'b000, 1, 1, 12'h555, 0, 6'h00, 1, 0);
    send(T5,  T5,  T5,  3'b111, 3'b000, 1, 1, 12'h555, 0, 6'h00, 1, 0);
    send(T5,  VID, T5,  3'b101, 3'b000, 1, 0, 12'h000, 0, 6'h00, 1, 1);
    send(T5,  T5,  T5,  3'b111, 3'b000, 1, 1, 12'h555, 0, 6'h00, 1, 1);
    send(T5,  VID, T5,  3'b101, 3'b000, 1, 0, 12'h000, 0, 6'h00, 1, 2);
    send(T5,  VID, T5,  3'b101, 3'b000, 0, 0, 12'h000, 0, 6'h00, 1, 3);
    send(T3,  T9,  TA,  3'b111, 3'b000, 0, 0, 12'h000, 0, 6'h00, 1, 3);
    send(T3,  T9,  TA,  3'b111, 3'b000, 1, 1, 12'hA93, 0, 6'h00, 2, 3);
    send(C11, C11, C11, 3'b000, 3'b111, 0, 0, 12'h000, 1, 6'h3F, 2, 3);
    send(T5,  T5,  T5,  3'b111, 3'b000, 0, 0, 12'h000, 0, 6'h00, 2, 3);
    send(VID, VID, VID, 3'b000, 3'b000, 0, 0, 12'h000, 0, 6'h00, 2, 3);
    send(VID, VID, VID, 3'b000, 3'b000, 0, 0, 12'h000, 0, 6'h00, 2, 3);
    send(T0,  T0,  T0,  3'b111, 3'b000, 0, 0, 12'h000, 0, 6'h00, 2, 3);
    send(T0,  T0,  T0,  3'b111, 3'b000, 1, 1, 12'h000, 0, 6'h00, 3, 3);
    send(T0,  VID, T0,  3'b101, 3'b000, 1, 0, 12'h000, 0, 6'h00, 3, 3);
    send(C00, C00, C00, 3'b000, 3'b111, 0, 0, 12'h000, 1, 6'h00, 3, 3);
    send(T5,  T5,  T5,  3'b111, 3'b000, 0, 0, 12'h000, 0, 6'h00, 3, 3);
    send(T5,  T5,  T5,  3'b111, 3'b000, 1, 1, 12'h555, 0, 6'h00, 3, 3);
    send(C00, C00, C00, 3'b000, 3'b111, 0, 0, 12'h000, 1, 6'h00, 3, 3);
    send(T5,  T5,  T5,  3'b111, 3'b000, 0, 0, 12'h000, 0, 6'h00, 3, 3);
    send(T5,  T5,  T5,  3'b111, 3'b000, 1, 1, 12'h555, 0, 6'h00, 3, 3);
    drain();

    // Still inside the island; reset must clear everything mid-cycle.
    chk("pre_reset_island_active", 32'(island_active), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_all_zero("midreset");
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/hdmi_island_detect.md
# hdmi_island_detect

Parametrised multi-channel TMDS symbol classifier and data-island tracker on the HDMI receive path, placed after the per-channel deserialisers in the 1x pixel-clock domain. Each channel's 10-bit symbol is classified as control, TERC4 or other, and the TERC4 nibble or control bits are decoded. A qualification state machine asserts island status only after a programmable run of all-channel TERC4 symbols, and tolerates a bounded number of corrupt symbols inside an island. Counters expose island and error statistics to the packet parser and debug logic.

## Interface
- NUM_CH, 3, number of TMDS channels, legal 1..4
- MIN_RUN, 2, consecutive all-channel TERC4 cycles needed to enter an island, legal 1..15
- MAX_ERR, 2, consecutive mixed cycles inside an island before dropping out, legal 1..15
- CNT_W, 16, width of the statistics counters
- clk_1x_in  in  1  pixel clock; one clock only
- rst_in  in  1  reset, asynchronous, active-high
- deser_data  in  10*NUM_CH  channel c occupies bits [10c+9:10c]
- is_terc4  out  NUM_CH  per-channel registered TERC4 match
- is_ctrl  out  NUM_CH  per-channel registered control-symbol match
- island_active  out  1  qualified data island in progress
- nib_valid  out  1  nib_data holds a valid all-channel TERC4 word
- nib_data  out  4*NUM_CH  decoded nibbles, channel c at [4c+3:4c]
- ctrl_valid  out  1  all channels carry control symbols
- ctrl_data  out  2*NUM_CH  decoded {c1,c0} per channel, channel c at [2c+1:2c]
- island_count  out  CNT_W  islands entered, saturating
- err_count  out  CNT_W  mixed cycles seen inside islands, saturating

## Operation
- TERC4 table, nibble 0..15: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011. No other code is TERC4.
- Control table, {c1,c0} 00..11: 1101010100, 0010101011, 0101010100, 1010101011.
- Stage 1, registered per channel: class (CTRL / TERC4 / OTHER), nibble, ctrl bits. The nibble is 0 when the symbol is not TERC4. The ctrl bits are 0 when the symbol is not control.
- all_ctrl = every channel CTRL. all_terc4 = every channel TERC4. mixed = neither.
- FSM states are S_OTHER, S_CTRL, S_QUAL and S_ISLAND. run is a 4-bit counter and err_run is a 4-bit counter.
- Transitions, with all_ctrl taking priority in every state:
  - all_ctrl: go to S_CTRL; clear run and err_run.
  - S_OTHER or S_CTRL with all_terc4: set run=1; go to S_ISLAND if MIN_RUN==1, otherwise S_QUAL.
  - S_OTHER or S_CTRL with mixed: go to S_OTHER.
  - S_QUAL with all_terc4: increment run; go to S_ISLAND when run+1==MIN_RUN.
  - S_QUAL with mixed: go to S_OTHER; clear run.
  - S_ISLAND with all_terc4: stay; clear err_run.
  - S_ISLAND with mixed: increment err_count. Go to S_OTHER when err_run+1==MAX_ERR, otherwise stay and increment err_run.
- island_count increments on every entry into S_ISLAND.
- Both counters saturate at all-ones and never wrap.
- island_active = state is S_ISLAND, registered.
- nib_valid = 1 only in S_ISLAND (including the entry cycle) while all_terc4. It is 0 during S_QUAL symbols; those nibbles are discarded.
- ctrl_valid = all_ctrl, pipelined. ctrl_data is valid only when ctrl_valid is 1.

## Timing
- Call the edge at which a symbol is sampled edge t.
- is_terc4 and is_ctrl update at edge t, for a latency of 1 cycle.
- island_active, nib_valid, nib_data, ctrl_valid, ctrl_data and both counters update at edge t+1, for a latency of 2 cycles.
- island_active rises 2 cycles after the MIN_RUN-th consecutive all-TERC4 symbol. nib_valid rises in the same cycle.
- While rst_in is asserted, all outputs are 0, the state is S_OTHER, and run and err_run are 0. This holds immediately and asynchronously, including when reset is asserted in the middle of an island.
- The first symbol after reset release is classified normally.
- A control symbol inside an island ends the island in the next FSM cycle, regardless of err_run.
- Throughput is one symbol per clock; there is no backpressure.

## Structure
- Package hdmi_symbol_pkg holds:
  - the TERC4 table as a 16-entry constant array;
  - the four control codes;
  - the symbol class enum: CTRL, TERC4, OTHER;
  - the FSM state enum.
- Sub-module terc4_decode_ch holds the per-channel stage-1 classify/decode and its registers. It is instantiated NUM_CH times by generate.
- The top level holds the FSM, the output pipeline and the counters.

## Test plan
- Reset, then all channels send 1101010100 -> ctrl_valid=1 and ctrl_data=0 from the 3rd edge; island_active=0.
- With MIN_RUN=2, all channels send nibble 5 (0100011110) for 4 cycles after control -> island_active and nib_valid rise 2 cycles after the 2nd TERC4 symbol; nib_data=0x555; island_count=1.
- In an island, channel 1 sends 1111111111 for 1 cycle (MAX_ERR=2) -> island_active stays 1, nib_valid=0 that cycle, err_count=1. With 2 consecutive such cycles -> island_active drops and err_count=2.
- In an island, all channels send control 1010101011 -> island_active=0 after 2 cycles; ctrl_data=0b111111.
- A single TERC4 cycle between control and video with MIN_RUN=2 -> island_active is never asserted; island_count is unchanged; is_terc4=3'b111 for exactly 1 cycle.
- Assert rst_in mid-island -> all outputs are 0 immediately. With CNT_W=2 and 5 islands entered -> island_count saturates at 3.
